// File: rtl/timer_pkg.sv
// Shared state encoding and defaults for the timer sequencer.
package timer_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLong  = 3'd1,
        StShort = 3'd2,
        StDone  = 3'd3,
        StErr   = 3'd4
    } timer_state_e;

    localparam int unsigned DefaultNumRounds = 2;
    localparam int unsigned DefaultWdogLimit = 255;
    localparam int unsigned RoundCntWidth    = 4;
    localparam int unsigned WdogCntWidth     = 10;

    function automatic logic is_active(timer_state_e state);
        return (state == StLong) || (state == StShort);
    endfunction

endpackage

// File: rtl/timer_seq_wdog.sv
// Per-phase cycle counter; flags a phase that has run WDOG_LIMIT cycles without finishing.
module timer_seq_wdog
    import timer_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT = DefaultWdogLimit
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_active,
    output logic o_expire
);

    // The count in a phase's first cycle is 0, so the LIMIT-th cycle sees LIMIT-1.
    localparam logic [WdogCntWidth-1:0] LastCount = WdogCntWidth'(WDOG_LIMIT - 1);

    logic [WdogCntWidth-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_active) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_active && (r_count == LastCount);

endmodule

// File: rtl/timer_seq_fsm.sv
// Sequences LONG->SHORT interval requests for NUM_ROUNDS rounds per run.
// Define TIMER_SEQ_WATCHDOG_EN to add the per-phase watchdog and the ERR state.
module timer_seq_fsm
    import timer_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = DefaultNumRounds,
    parameter int unsigned WDOG_LIMIT = DefaultWdogLimit
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       done_counter,
    input  logic       almost_done,
    output logic       i_short_counter,
    output logic       i_long_counter,
    output logic       done_FSM,
    output logic [2:0] o_phase,
    output logic       o_warn,
    output logic       o_error
);

    localparam logic [RoundCntWidth-1:0] LastRound = RoundCntWidth'(NUM_ROUNDS);

    timer_state_e             r_state;
    timer_state_e             w_state_next;
    logic [RoundCntWidth-1:0] r_round;
    logic [RoundCntWidth-1:0] w_round_next;
    logic [RoundCntWidth-1:0] w_round_inc;
    logic                     r_long;
    logic                     r_short;
    logic                     r_done;
    logic                     r_warn;
    logic                     w_wdog_expire;

    assign w_round_inc = r_round + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_round_next = r_round;
        if (i_abort) begin
            w_state_next = StIdle;
            w_round_next = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_round_next = '0;
                    if (i_start) begin
                        w_state_next = StLong;
                    end
                end
                StLong: begin
                    if (done_counter) begin
                        w_state_next = StShort;
                    end else if (w_wdog_expire) begin
                        w_state_next = StErr;
                    end
                end
                StShort: begin
                    if (done_counter) begin
                        w_round_next = w_round_inc;
                        w_state_next = (w_round_inc == LastRound) ? StDone : StLong;
                    end else if (w_wdog_expire) begin
                        w_state_next = StErr;
                    end
                end
                StDone: begin
                    w_state_next = StIdle;
                    w_round_next = '0;
                end
                StErr: begin
                    w_round_next = '0;
                end
                default: begin
                    w_state_next = StIdle;
                    w_round_next = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_round <= '0;
            r_long  <= 1'b0;
            r_short <= 1'b0;
            r_done  <= 1'b0;
            r_warn  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_round <= w_round_next;
            r_long  <= (w_state_next == StLong);
            r_short <= (w_state_next == StShort);
            r_done  <= (w_state_next == StDone);
            r_warn  <= almost_done && is_active(r_state) && is_active(w_state_next);
        end
    end

    assign i_long_counter  = r_long;
    assign i_short_counter = r_short;
    assign done_FSM        = r_done;
    assign o_warn          = r_warn;
    assign o_phase         = r_state;

`ifdef TIMER_SEQ_WATCHDOG_EN
    logic w_wdog_clear;
    logic r_error;

    assign w_wdog_clear = (w_state_next != r_state);

    timer_seq_wdog #(
        .WDOG_LIMIT(WDOG_LIMIT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_wdog_clear),
        .i_active (is_active(r_state)),
        .o_expire (w_wdog_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_error <= 1'b0;
        end else begin
            r_error <= (w_state_next == StErr);
        end
    end

    assign o_error = r_error;
`else
    logic w_unused_wdog_limit;

    assign w_unused_wdog_limit = ^(WdogCntWidth'(WDOG_LIMIT));
    assign w_wdog_expire       = 1'b0;
    assign o_error             = 1'b0;
`endif

endmodule

// File: tb/tb_timer_seq_fsm.sv
// Self-checking bench for timer_seq_fsm: a default DUT driven by a counter model, plus a
// NUM_ROUNDS=1 / WDOG_LIMIT=20 DUT sharing the inputs for restart and watchdog scenarios.
module tb_timer_seq_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start;
    logic       i_abort;
    logic       done_counter;
    logic       almost_done;

    logic       long0, short0, done0, warn0, err0;
    logic [2:0] phase0;
    logic       long1, short1, done1, warn1, err1;
    logic [2:0] phase1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit model_en = 1'b0;
    int m_req    = 0;
    int m_cnt    = 0;
    int m_len    = 0;

    int exp_phase_q[$];
    int exp_done_q[$];

    always #5 clk = ~clk;

    timer_seq_fsm u_dut0 (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (i_start),
        .i_abort         (i_abort),
        .done_counter    (done_counter),
        .almost_done     (almost_done),
        .i_short_counter (short0),
        .i_long_counter  (long0),
        .done_FSM        (done0),
        .o_phase         (phase0),
        .o_warn          (warn0),
        .o_error         (err0)
    );

    timer_seq_fsm #(
        .NUM_ROUNDS (1),
        .WDOG_LIMIT (20)
    ) u_dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (i_start),
        .i_abort         (i_abort),
        .done_counter    (done_counter),
        .almost_done     (almost_done),
        .i_short_counter (short1),
        .i_long_counter  (long1),
        .done_FSM        (done1),
        .o_phase         (phase1),
        .o_warn          (warn1),
        .o_error         (err1)
    );

    // Requests must never both be high on either DUT.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if ((long0 && short0) || (long1 && short1)) begin
                failures++;
                $display("FAIL req_exclusive t=%0t dut0 L=%b S=%b dut1 L=%b S=%b required not both 1",
                         $time, long0, short0, long1, short1);
            end
        end
    end

    // One clock; when enabled, the counter model (long=64, short=16) drives the pulses.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (model_en) begin
            if (long0) begin
                if (m_req != 1) begin m_req = 1; m_cnt = 1; end
                else m_cnt++;
            end else if (short0) begin
                if (m_req != 2) begin m_req = 2; m_cnt = 1; end
                else m_cnt++;
            end else begin
                m_req = 0;
                m_cnt = 0;
            end
            m_len        = (m_req == 1) ? 64 : 16;
            done_counter = (m_req != 0) && (m_cnt == m_len);
            almost_done  = (m_req != 0) && (m_cnt == m_len - 1);
        end
    endtask

    task automatic pulse_done();
        done_counter = 1'b1;
        step();
        done_counter = 1'b0;
    endtask

    task automatic abort_all();
        i_start      = 1'b0;
        done_counter = 1'b0;
        almost_done  = 1'b0;
        i_abort      = 1'b1;
        step();
        i_abort      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        i_start      = 1'b0;
        i_abort      = 1'b0;
        done_counter = 1'b0;
        almost_done  = 1'b0;
        repeat (3) step();
        checks++;
        if (phase0 !== 3'd0) begin
            failures++;
            $display("FAIL reset_phase got=%0d exp=0", phase0);
        end
        checks++;
        if ({long0, short0, done0, warn0, err0} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000", {long0, short0, done0, warn0, err0});
        end
        checks++;
        if ({phase1, long1, short1, done1, warn1, err1} !== 8'b0) begin
            failures++;
            $display("FAIL reset_dut1 got=%b exp=00000000",
                     {phase1, long1, short1, done1, warn1, err1});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (phase0 !== 3'd0) begin
            failures++;
            $display("FAIL reset_release_idle got=%0d exp=0", phase0);
        end
    endtask

    task automatic test_run();
        int  shorts_done = 0;
        int  done_seen   = 0;
        int  req_err     = 0;
        int  warn_err    = 0;
        int  prev_phase;
        int  n           = 0;
        int  e;
        bit  finished    = 1'b0;
        bit  prev_alm;
        bit  prev_act;
        logic [2:0] e3;

        exp_phase_q = '{1, 2, 1, 2, 3, 0};
        exp_done_q.delete();
        m_req      = 0;
        m_cnt      = 0;
        model_en   = 1'b1;
        prev_phase = int'(phase0);
        i_start    = 1'b1;
        while (!finished && n < 400) begin
            prev_alm = almost_done;
            prev_act = (phase0 == 3'd1) || (phase0 == 3'd2);
            if (done_counter && short0) begin
                shorts_done++;
                if (shorts_done == 2) exp_done_q.push_back(cyc + 1);
            end
            step();
            i_start = 1'b0;
            n++;
            if (int'(phase0) != prev_phase) begin
                checks++;
                if (exp_phase_q.size() == 0) begin
                    failures++;
                    $display("FAIL run_phase got=%0d exp=none (unexpected transition)", phase0);
                end else begin
                    e  = exp_phase_q.pop_front();
                    e3 = 3'(e);
                    if (phase0 !== e3) begin
                        failures++;
                        $display("FAIL run_phase got=%0d exp=%0d", phase0, e3);
                    end
                end
                if (phase0 == 3'd0) finished = 1'b1;
                prev_phase = int'(phase0);
            end
            if (done0) begin
                done_seen++;
                checks++;
                if (exp_done_q.size() == 0) begin
                    failures++;
                    $display("FAIL run_done_latency got=cycle %0d exp=none", cyc);
                end else begin
                    e = exp_done_q.pop_front();
                    if (cyc != e) begin
                        failures++;
                        $display("FAIL run_done_latency got=cycle %0d exp=cycle %0d", cyc, e);
                    end
                end
            end
            if ({long0, short0, done0} !== {phase0 == 3'd1, phase0 == 3'd2, phase0 == 3'd3})
                req_err++;
            if (warn0 !== (prev_alm && prev_act)) warn_err++;
        end
        model_en     = 1'b0;
        done_counter = 1'b0;
        almost_done  = 1'b0;
        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL run_timeout got=%0d cycles exp=return to IDLE within 400", n);
        end
        checks++;
        if (exp_phase_q.size() != 0) begin
            failures++;
            $display("FAIL run_phase_left got=%0d pending exp=0", exp_phase_q.size());
        end
        checks++;
        if (done_seen != 1) begin
            failures++;
            $display("FAIL run_done_count got=%0d exp=1", done_seen);
        end
        checks++;
        if (req_err != 0) begin
            failures++;
            $display("FAIL run_requests got=%0d bad cycles exp=0", req_err);
        end
        checks++;
        if (warn_err != 0) begin
            failures++;
            $display("FAIL run_warn got=%0d bad cycles exp=0", warn_err);
        end
    endtask

    task automatic test_warn();
        abort_all();
        almost_done = 1'b1;
        step();
        almost_done = 1'b0;
        checks++;
        if (warn0 !== 1'b0) begin
            failures++;
            $display("FAIL warn_idle got=%b exp=0", warn0);
        end
        step();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (3) step();
        almost_done = 1'b1;
        step();
        almost_done = 1'b0;
        checks++;
        if (warn0 !== 1'b1) begin
            failures++;
            $display("FAIL warn_long got=%b exp=1", warn0);
        end
        step();
        checks++;
        if (warn0 !== 1'b0) begin
            failures++;
            $display("FAIL warn_long_clear got=%b exp=0", warn0);
        end
        abort_all();
    endtask

    task automatic test_abort();
        abort_all();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        pulse_done();
        step();
        pulse_done();
        step();
        pulse_done();
        checks++;
        if (phase0 !== 3'd2) begin
            failures++;
            $display("FAIL abort_setup got=%0d exp=2", phase0);
        end
        step();
        done_counter = 1'b1;
        i_abort      = 1'b1;
        step();
        done_counter = 1'b0;
        i_abort      = 1'b0;
        checks++;
        if ({phase0, long0, short0, done0} !== 6'b0) begin
            failures++;
            $display("FAIL abort_priority got=phase %0d L%b S%b D%b exp=phase 0 L0 S0 D0",
                     phase0, long0, short0, done0);
        end
        step();
        checks++;
        if ({phase0, done0} !== 4'b0) begin
            failures++;
            $display("FAIL abort_no_done got=phase %0d D%b exp=phase 0 D0", phase0, done0);
        end
        // With the round count cleared, one LONG/SHORT pair must lead back to LONG.
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        pulse_done();
        pulse_done();
        checks++;
        if (phase0 !== 3'd1) begin
            failures++;
            $display("FAIL abort_round_clear got=%0d exp=1", phase0);
        end
        abort_all();
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        abort_all();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (29) step();
        checks++;
        if (long0 !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got=%b exp=1", long0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({long0, phase0} !== 4'b0) begin
            failures++;
            $display("FAIL rstmid_async got=L%b phase %0d exp=L0 phase 0", long0, phase0);
        end
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) begin
            step();
            if (phase0 !== 3'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rstmid_wait got=%0d non-idle cycles exp=0", bad);
        end
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        checks++;
        if (phase0 !== 3'd1) begin
            failures++;
            $display("FAIL rstmid_restart got=%0d exp=1", phase0);
        end
        abort_all();
    endtask

    task automatic test_back_to_back();
        abort_all();
        i_start = 1'b1;
        step();
        checks++;
        if (phase1 !== 3'd1) begin
            failures++;
            $display("FAIL b2b_long got=%0d exp=1", phase1);
        end
        step();
        pulse_done();
        checks++;
        if (phase1 !== 3'd2) begin
            failures++;
            $display("FAIL b2b_short got=%0d exp=2", phase1);
        end
        step();
        pulse_done();
        checks++;
        if ({phase1, done1, long1, short1} !== {3'd3, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_done got=phase %0d D%b L%b S%b exp=phase 3 D1 L0 S0",
                     phase1, done1, long1, short1);
        end
        step();
        checks++;
        if ({phase1, done1} !== {3'd0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_idle got=phase %0d D%b exp=phase 0 D0", phase1, done1);
        end
        step();
        checks++;
        if ({phase1, long1} !== {3'd1, 1'b1}) begin
            failures++;
            $display("FAIL b2b_restart got=phase %0d L%b exp=phase 1 L1", phase1, long1);
        end
        abort_all();
    endtask

    task automatic test_watchdog();
        abort_all();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
`ifdef TIMER_SEQ_WATCHDOG_EN
        repeat (19) step();
        checks++;
        if ({phase1, err1} !== {3'd1, 1'b0}) begin
            failures++;
            $display("FAIL wdog_cycle20 got=phase %0d E%b exp=phase 1 E0", phase1, err1);
        end
        step();
        checks++;
        if ({phase1, err1, long1, short1} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL wdog_cycle21 got=phase %0d E%b L%b S%b exp=phase 4 E1 L0 S0",
                     phase1, err1, long1, short1);
        end
        repeat (5) step();
        checks++;
        if ({phase1, err1} !== {3'd4, 1'b1}) begin
            failures++;
            $display("FAIL wdog_hold got=phase %0d E%b exp=phase 4 E1", phase1, err1);
        end
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        checks++;
        if ({phase1, err1} !== {3'd0, 1'b0}) begin
            failures++;
            $display("FAIL wdog_abort got=phase %0d E%b exp=phase 0 E0", phase1, err1);
        end
`else
        repeat (30) step();
        checks++;
        if ({phase1, err1} !== {3'd1, 1'b0}) begin
            failures++;
            $display("FAIL wdog_absent got=phase %0d E%b exp=phase 1 E0", phase1, err1);
        end
        abort_all();
`endif
    endtask

    initial begin
        test_reset();
        test_run();
        test_warn();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_seq_fsm.md
TIMER_SEQ_FSM -- requirements
Module: timer_seq_fsm

Interface
REQ-001 Parameter NUM_ROUNDS, default 2: LONG->SHORT round pairs per run, range 1..15.
REQ-002 Parameter WDOG_LIMIT, default 255: maximum cycles per phase before a watchdog error, range 2..1023.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_start  input  1  level; sampled in IDLE, starts a run.
REQ-006 i_abort  input  1  level; returns to IDLE from any state.
REQ-007 done_counter  input  1  one-cycle pulse from the counter at terminal count.
REQ-008 almost_done  input  1  one-cycle pulse from the counter, one cycle before done_counter.
REQ-009 i_short_counter  output  1  registered short-interval request to the counter.
REQ-010 i_long_counter  output  1  registered long-interval request to the counter.
REQ-011 done_FSM  output  1  one-cycle pulse at end of run.
REQ-012 o_phase  output  3  encoded current state.
REQ-013 o_warn  output  1  registered almost_done, gated by an active phase.
REQ-014 o_error  output  1  watchdog error flag.

Function
REQ-015 States SHALL be IDLE=0, LONG=1, SHORT=2, DONE=3, ERR=4; o_phase SHALL equal the state code.
REQ-016 IDLE: both requests SHALL be low; i_start=1 SHALL move to LONG on the next edge; round count SHALL clear to 0.
REQ-017 LONG: i_long_counter=1 and i_short_counter=0; done_counter=1 SHALL move to SHORT on the next edge.
REQ-018 SHORT: i_short_counter=1 and i_long_counter=0; on done_counter=1 the round count SHALL increment; the FSM SHALL go to DONE if the new count equals NUM_ROUNDS, else to LONG.
REQ-019 Requests SHALL be one-hot in LONG/SHORT and never both high in any cycle.
REQ-020 DONE SHALL last exactly one cycle with both requests low and done_FSM=1, then go to IDLE.
REQ-021 Latency: done_FSM SHALL rise exactly one cycle after the final SHORT done_counter.
REQ-022 o_warn SHALL equal almost_done delayed one cycle while the state is LONG or SHORT, else 0.
REQ-023 done_counter or almost_done arriving in IDLE/DONE/ERR SHALL be ignored.
REQ-024 i_abort SHALL take priority over every other event, including a simultaneous done_counter: next state IDLE, round count 0, requests low, no done_FSM.
REQ-025 i_start held high after DONE SHALL start a new run one cycle after returning to IDLE, i.e. IDLE lasts one cycle.
REQ-026 Round counter width SHALL be 4 bits; it SHALL never wrap because NUM_ROUNDS<=15.

Reset
REQ-027 rst_n=0 SHALL force, asynchronously, state=IDLE, round count 0, watchdog count 0, and all outputs 0.
REQ-028 Reset mid-run SHALL drop requests immediately; after release the FSM SHALL wait for a fresh i_start.

Configuration
REQ-029 Macro TIMER_SEQ_WATCHDOG_EN defined: a 10-bit phase-cycle counter SHALL clear on every state entry and increment each cycle in LONG/SHORT.
REQ-030 With the macro, the counter reaching WDOG_LIMIT without done_counter SHALL move the FSM to ERR on the next edge.
REQ-031 ERR: requests low, o_error=1, held until i_abort or reset.
REQ-032 Macro undefined: no watchdog logic, o_error tied 0, and ERR unreachable.

Structure
REQ-033 Shared package timer_pkg SHALL hold the state enum typedef (3-bit), the default NUM_ROUNDS, and the default WDOG_LIMIT.
REQ-034 Sub-module timer_seq_wdog SHALL implement the watchdog counter and be instantiated only under TIMER_SEQ_WATCHDOG_EN.

Verification
REQ-035 Reset 3 cycles, i_start=1 for 1 cycle, counter model (long=64, short=16) -> requests L,S,L,S; done_FSM pulses once, 1 cycle after the 2nd short done; o_phase returns to 0.
REQ-036 Drive almost_done in LONG -> o_warn=1 exactly one cycle later; drive almost_done in IDLE -> o_warn stays 0.
REQ-037 i_abort asserted in the same cycle as done_counter in SHORT -> next state IDLE, no done_FSM, round count 0.
REQ-038 rst_n dropped at cycle 30 of LONG -> i_long_counter=0 without waiting for a clock edge; after release, o_phase=0 until i_start.
REQ-039 With TIMER_SEQ_WATCHDOG_EN and WDOG_LIMIT=20, withhold done_counter -> ERR and o_error=1 at cycle 21 of phase, held until i_abort, then IDLE.
REQ-040 i_start held high through the whole run, NUM_ROUNDS=1 -> DONE, IDLE for 1 cycle, LONG again; requests never both high (assertion throughout).
